// File: rtl/mem_arbiter_pkg.sv
// Shared CPU-side definitions for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    localparam int STARVE_MAX_DEFAULT = 3;
    localparam int STARVE_W           = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_IF = 2'd1,
        ST_GRANT_DM = 2'd2,
        ST_RESP     = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arb_cmd_reg.sv
// Latched shared-memory command and captured read data.
// Command loads on grant; read data loads on memory completion.
module mem_arb_cmd_reg
    import mem_arbiter_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_cmd_load,
    input  mem_cmd_t    i_cmd,
    input  logic        i_rdata_load,
    input  logic [31:0] i_rdata,
    output mem_cmd_t    o_cmd,
    output logic [31:0] o_rdata
);

    mem_cmd_t    r_cmd;
    logic [31:0] r_rdata;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cmd <= '0;
        end else if (i_cmd_load) begin
            r_cmd <= i_cmd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rdata <= 32'h0;
        end else if (i_rdata_load) begin
            r_rdata <= i_rdata;
        end
    end

    assign o_cmd   = r_cmd;
    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one shared memory, DM-first with IF anti-starvation.
// Ack pulses the cycle after mem_ack_i; requesters are stalled while their request is unacknowledged.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_ack_o,
    output logic [31:0] dm_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o
);

    localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [STARVE_W-1:0] r_starve;
    logic                r_mem_req;
    logic                r_resp_dm;
    logic                w_grant_if;
    logic                w_grant_dm;
    logic                w_cmd_load;
    logic                w_rdata_load;
    mem_cmd_t            w_cmd_in;
    mem_cmd_t            w_cmd;
    logic [31:0]         w_rdata;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_if   = 1'b0;
        w_grant_dm   = 1'b0;
        w_rdata_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // DM wins ties until the fetch has waited STARVE_MAX grants.
                if (dm_req_i && (!if_req_i || (r_starve != STARVE_MAX_C))) begin
                    w_grant_dm  = 1'b1;
                    w_state_nxt = ST_GRANT_DM;
                end else if (if_req_i) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = ST_GRANT_IF;
                end
            end
            ST_GRANT_IF, ST_GRANT_DM: begin
                if (mem_ack_i) begin
                    w_rdata_load = 1'b1;
                    w_state_nxt  = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_cmd_load = w_grant_if | w_grant_dm;

    always_comb begin
        w_cmd_in = '0;
        if (w_grant_dm) begin
            w_cmd_in.we    = dm_we_i;
            w_cmd_in.addr  = dm_addr_i;
            w_cmd_in.wdata = dm_wdata_i;
        end else begin
            w_cmd_in.addr  = if_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mem_req <= 1'b0;
            r_resp_dm <= 1'b0;
        end else begin
            if (w_cmd_load) begin
                r_mem_req <= 1'b1;
                r_resp_dm <= w_grant_dm;
            end else if (w_rdata_load) begin
                r_mem_req <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_starve <= '0;
        end else if (w_grant_if) begin
            r_starve <= '0;
        end else if (w_grant_dm) begin
            if (!if_req_i) begin
                r_starve <= '0;
            end else if (r_starve != STARVE_MAX_C) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    mem_arb_cmd_reg u_cmd_reg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_cmd_load   (w_cmd_load),
        .i_cmd        (w_cmd_in),
        .i_rdata_load (w_rdata_load),
        .i_rdata      (mem_rdata_i),
        .o_cmd        (w_cmd),
        .o_rdata      (w_rdata)
    );

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = w_cmd.we;
    assign mem_addr_o  = w_cmd.addr;
    assign mem_wdata_o = w_cmd.wdata;

    assign if_ack_o    = (r_state == ST_RESP) & ~r_resp_dm;
    assign dm_ack_o    = (r_state == ST_RESP) &  r_resp_dm;
    assign if_rdata_o  = w_rdata;
    assign dm_rdata_o  = w_rdata;

    // Gated by reset so every output reads zero while rst_i is low.
    assign stall_o = rst_i & ((if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: requester drivers, memory responder, output monitor.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i, dm_req_i, dm_we_i, mem_ack_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
    logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, stall_o;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;

    mem_arbiter #(.STARVE_MAX(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } dreq_t;
    typedef struct { logic care; logic [31:0] rdata; } ack_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic chk_wd; } gnt_t;

    logic [31:0] if_cmd_q[$];
    dreq_t       dm_cmd_q[$];
    ack_t        if_exp_q[$];
    ack_t        dm_exp_q[$];
    gnt_t        gnt_exp_q[$];
    logic [31:0] mem_st [logic [31:0]];

    int n_chk = 0, n_pass = 0;
    int ack_dly = 2, dcnt = 0;
    int cyc = 0, grant_cyc = 0, if_ack_cyc = 0;
    int if_issued = 0, dm_issued = 0, if_acks = 0, dm_acks = 0;
    logic stray_ack = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (mem_st.exists(a)) return mem_st[a];
        if (a == 32'h10) return 32'h8C020004;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Requester drivers: hold request until ack, then issue next queued command.
    always @(negedge clk_i) begin
        if (if_req_i && if_ack_o) if_req_i = 1'b0;
        if (rst_i && !if_req_i && if_cmd_q.size() > 0) begin
            if_addr_i = if_cmd_q.pop_front();
            if_req_i  = 1'b1;
            if_exp_q.push_back('{care: 1'b1, rdata: rd_model(if_addr_i)});
            if_issued++;
        end
    end

    always @(negedge clk_i) begin
        dreq_t d;
        if (dm_req_i && dm_ack_o) dm_req_i = 1'b0;
        if (rst_i && !dm_req_i && dm_cmd_q.size() > 0) begin
            d = dm_cmd_q.pop_front();
            dm_we_i    = d.we;
            dm_addr_i  = d.addr;
            dm_wdata_i = d.wdata;
            dm_req_i   = 1'b1;
            dm_exp_q.push_back('{care: !d.we, rdata: rd_model(d.addr)});
            dm_issued++;
        end
    end

    // Memory responder: acks ack_dly cycles after mem_req_o rises.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            mem_ack_i = 1'b0;
            dcnt = 0;
        end else if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            dcnt = 0;
        end else if (stray_ack) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hBAD0BAD0;
            stray_ack   = 1'b0;
        end else if (mem_req_o) begin
            dcnt++;
            if (dcnt >= ack_dly) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem_we_o ? 32'h0 : rd_model(mem_addr_o);
                if (mem_we_o) mem_st[mem_addr_o] = mem_wdata_o;
            end
        end
    end

    // Output monitor: grants, command stability, acks and stall, sampled 1ns after the edge.
    logic prev_req = 1'b0;
    gnt_t cur_g;
    always @(posedge clk_i) begin
        gnt_t g;
        ack_t a;
        #1;
        cyc++;
        if (mem_req_o && !prev_req) begin
            grant_cyc = cyc;
            chk("grant_expected", 32'(gnt_exp_q.size() != 0), 32'd1);
            if (gnt_exp_q.size() != 0) begin
                g = gnt_exp_q.pop_front();
                chk("grant_we", 32'(mem_we_o), 32'(g.we));
                chk("grant_addr", mem_addr_o, g.addr);
                if (g.chk_wd) chk("grant_wdata", mem_wdata_o, g.wdata);
            end
            cur_g = '{we: mem_we_o, addr: mem_addr_o, wdata: mem_wdata_o, chk_wd: 1'b1};
        end else if (mem_req_o) begin
            chk("cmd_stable_addr", mem_addr_o, cur_g.addr);
            chk("cmd_stable_we", 32'(mem_we_o), 32'(cur_g.we));
            chk("cmd_stable_wdata", mem_wdata_o, cur_g.wdata);
        end
        prev_req = mem_req_o;
        if (if_ack_o || dm_ack_o) chk("ack_onehot", 32'(if_ack_o & dm_ack_o), 32'd0);
        if (if_ack_o) begin
            if_acks++;
            if_ack_cyc = cyc;
            chk("if_ack_expected", 32'(if_exp_q.size() != 0), 32'd1);
            if (if_exp_q.size() != 0) begin
                a = if_exp_q.pop_front();
                chk("if_rdata", if_rdata_o, a.rdata);
            end
        end
        if (dm_ack_o) begin
            dm_acks++;
            chk("dm_ack_expected", 32'(dm_exp_q.size() != 0), 32'd1);
            if (dm_exp_q.size() != 0) begin
                a = dm_exp_q.pop_front();
                if (a.care) chk("dm_rdata", dm_rdata_o, a.rdata);
            end
        end
        chk("stall", 32'(stall_o),
            32'(rst_i & ((if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o))));
    end

    task automatic wait_idle(input string tag, input int budget);
        logic quiet;
        quiet = 1'b0;
        for (int i = 0; i < budget && !quiet; i++) begin
            @(posedge clk_i); #2;
            quiet = (if_cmd_q.size() == 0) && (dm_cmd_q.size() == 0) &&
                    (if_exp_q.size() == 0) && (dm_exp_q.size() == 0) &&
                    !if_req_i && !dm_req_i && !mem_req_o;
        end
        chk(tag, 32'(quiet), 32'd1);
    endtask

    task automatic wait_memreq(input string tag);
        for (int i = 0; i < 50 && !mem_req_o; i++) begin
            @(posedge clk_i); #2;
        end
        chk(tag, 32'(mem_req_o), 32'd1);
    endtask

    initial begin
        rst_i = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b1; dm_we_i = 1'b0; mem_ack_i = 1'b0;
        if_addr_i = 32'h0; dm_addr_i = 32'h44; dm_wdata_i = 32'h0; mem_rdata_i = 32'h0;
        #7;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_acks", 32'({if_ack_o, dm_ack_o}), 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'h0);
        chk("rst_dm_rdata", dm_rdata_o, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        dm_req_i = 1'b0;
        @(posedge clk_i); #3 rst_i = 1'b1;

        // Lone fetch, ack two cycles after request.
        gnt_exp_q.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, chk_wd: 1'b0});
        if_cmd_q.push_back(32'h10);
        wait_idle("idle_lone_if", 60);
        chk("if_ack_latency", 32'(if_ack_cyc - grant_cyc), 32'd2);

        // Simultaneous store and fetch: DM first.
        gnt_exp_q.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'hDEADBEEF, chk_wd: 1'b1});
        gnt_exp_q.push_back('{we: 1'b0, addr: 32'h14, wdata: 32'h0, chk_wd: 1'b0});
        dm_cmd_q.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'hDEADBEEF});
        if_cmd_q.push_back(32'h14);
        wait_idle("idle_both", 80);

        // Starvation limit: DM, DM, DM, IF, then the remaining DM.
        gnt_exp_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0, chk_wd: 1'b0});
        gnt_exp_q.push_back('{we: 1'b0, addr: 32'h204, wdata: 32'h0, chk_wd: 1'b0});
        gnt_exp_q.push_back('{we: 1'b0, addr: 32'h208, wdata: 32'h0, chk_wd: 1'b0});
        gnt_exp_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, chk_wd: 1'b0});
        gnt_exp_q.push_back('{we: 1'b0, addr: 32'h20C, wdata: 32'h0, chk_wd: 1'b0});
        for (int i = 0; i < 4; i++)
            dm_cmd_q.push_back('{we: 1'b0, addr: 32'h200 + 32'(4 * i), wdata: 32'h0});
        if_cmd_q.push_back(32'h100);
        wait_idle("idle_starve", 200);

        // Requester changes its inputs mid-transaction.
        ack_dly = 4;
        gnt_exp_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, chk_wd: 1'b0});
        dm_cmd_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
        wait_memreq("memreq_midchange");
        @(negedge clk_i);
        dm_addr_i = 32'h999; dm_we_i = 1'b1; dm_wdata_i = 32'h12345678;
        wait_idle("idle_midchange", 60);
        ack_dly = 2;

        // Stray memory ack while idle.
        stray_ack = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("stray_no_req", 32'(mem_req_o), 32'd0);
        chk("stray_no_ack", 32'({if_ack_o, dm_ack_o}), 32'd0);
        gnt_exp_q.push_back('{we: 1'b0, addr: 32'h18, wdata: 32'h0, chk_wd: 1'b0});
        if_cmd_q.push_back(32'h18);
        wait_idle("idle_after_stray", 60);

        // Reset during a DM grant abandons it.
        ack_dly = 20;
        gnt_exp_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h0, chk_wd: 1'b0});
        dm_cmd_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h0});
        wait_memreq("memreq_before_rst");
        @(posedge clk_i); #3 rst_i = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req_o), 32'd0);
        chk("midrst_dm_ack", 32'(dm_ack_o), 32'd0);
        chk("midrst_mem_addr", mem_addr_o, 32'h0);
        dm_req_i = 1'b0;
        dm_exp_q.delete();
        dm_issued--;
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b1;
        ack_dly = 2;
        gnt_exp_q.push_back('{we: 1'b0, addr: 32'h504, wdata: 32'h0, chk_wd: 1'b0});
        dm_cmd_q.push_back('{we: 1'b0, addr: 32'h504, wdata: 32'h0});
        wait_idle("idle_after_rst", 60);

        chk("if_ack_count", 32'(if_acks), 32'(if_issued));
        chk("dm_ack_count", 32'(dm_acks), 32'(dm_issued));
        chk("grants_consumed", 32'(gnt_exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3: maximum consecutive data-port grants while a fetch is waiting.
REQ-002 Port clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 Port rst_i  in  1  reset, asynchronous, active-low.
REQ-004 Port if_req_i  in  1  instruction-fetch request; held high until if_ack_o.
REQ-005 Port if_addr_i  in  32  fetch byte address.
REQ-006 Port if_ack_o  out  1  one-cycle fetch completion pulse.
REQ-007 Port if_rdata_o  out  32  fetched instruction; valid while if_ack_o is high.
REQ-008 Port dm_req_i  in  1  data request; held high until dm_ack_o.
REQ-009 Port dm_we_i  in  1  1 = store, 0 = load.
REQ-010 Port dm_addr_i  in  32  data byte address.
REQ-011 Port dm_wdata_i  in  32  store data.
REQ-012 Port dm_ack_o  out  1  one-cycle data completion pulse.
REQ-013 Port dm_rdata_o  out  32  load data; valid while dm_ack_o is high.
REQ-014 Port mem_req_o  out  1  shared-memory request; held until mem_ack_i.
REQ-015 Port mem_we_o, mem_addr_o[32], mem_wdata_o[32]  out  shared-memory command fields.
REQ-016 Port mem_ack_i  in  1  memory completion; arrives 1..N cycles after mem_req_o.
REQ-017 Port mem_rdata_i  in  32  memory read data; valid with mem_ack_i.
REQ-018 Port stall_o  out  1  pipeline freeze request to the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.

Function
REQ-019 States: IDLE, GRANT_IF, GRANT_DM, RESP.
REQ-020 IDLE with no request: stay in IDLE with mem_req_o=0.
REQ-021 IDLE with only one request: grant that requester.
REQ-022 IDLE with both requests: grant DM, unless starve_cnt==STARVE_MAX, in which case grant IF.
REQ-023 On grant: latch address, we and wdata into command registers, and enter GRANT_IF or GRANT_DM.
REQ-024 mem_req_o is registered: it rises the cycle after the grant decision.
REQ-025 mem_we_o is 0 on IF grants.
REQ-026 Command outputs stay stable until mem_ack_i, even if requester inputs change.
REQ-027 In GRANT_x, when mem_ack_i=1: register mem_rdata_i, drop mem_req_o the next cycle, and enter RESP.
REQ-028 In RESP, pulse exactly one of if_ack_o/dm_ack_o for one cycle with the registered rdata, then return to IDLE.
REQ-029 A requester may re-request in the same cycle as its ack without a bubble beyond IDLE.
REQ-030 For stores, dm_rdata_o is don't-care and is driven with the registered data.
REQ-031 starve_cnt is 2 bits wide.
REQ-032 starve_cnt increments on each DM grant made while if_req_i=1.
REQ-033 starve_cnt clears on any IF grant and on any DM grant made while if_req_i=0.
REQ-034 starve_cnt saturates at STARVE_MAX.
REQ-035 stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational.
REQ-036 stall_o is low in the cycle either ack pulses for the only pending requester.
REQ-037 mem_ack_i outside GRANT_x is ignored.
REQ-038 A request deasserted before its ack is a protocol violation; the in-flight transaction still completes and its ack is still pulsed.

Reset
REQ-039 When rst_i=0: state=IDLE, starve_cnt=0, and all outputs 0 (rdata 32'h0), regardless of clock.
REQ-040 Reset during GRANT_x abandons the transaction with no ack, and mem_req_o drops immediately.
REQ-041 After reset release, the first grant is made no earlier than the first rising edge with rst_i=1.

Structure
REQ-042 State encoding and default STARVE_MAX live in the shared CPU package.
REQ-043 One sub-module, mem_arb_cmd_reg, holds the latched command and rdata registers.
REQ-044 The FSM and the starvation counter are inline in mem_arbiter.

Verification
REQ-045 Lone IF request at 0x10, mem_ack_i 2 cycles after mem_req_o, rdata 0x8C020004 -> if_ack_o pulses once with 0x8C020004; mem_we_o=0 throughout.
REQ-046 IF and DM request together, DM store of 0xDEADBEEF to 0x40 -> DM granted first (mem_we_o=1, mem_addr_o=0x40), then IF; stall_o high until the last ack.
REQ-047 DM request held continuously with IF pending, STARVE_MAX=3 -> the grant sequence is DM, DM, DM, IF.
REQ-048 rst_i pulled low while in GRANT_DM -> mem_req_o=0 asynchronously, no dm_ack_o; after release a fresh request completes normally.
REQ-049 Requester changes dm_addr_i mid-transaction -> mem_addr_o holds the latched value until mem_ack_i.
REQ-050 mem_ack_i pulsed while IDLE -> no ack output and no state change.
